sopc_cap_debug_slave_cmd_sync: RTL and testbench
================================================

# sopc_cap_debug_slave_cmd_sync

This block is the system-clock stage downstream of the Nios II debug-slave JTAG wrapper. It receives the TCK-domain update strobes (`vs_udr`, `vs_uir`), the instruction register (`ir_in`) and the shift register (`sr`) and synchronises the strobes into `clk`. On each update it captures `sr` into `jdo` and decodes the latched instruction and `jdo` command bits into single-cycle `take_action_*` / `take_no_action_*` pulses for the OCI memory, break and trace-control units.

## Interface
- `SYNC_DEPTH`, default 2: synchroniser flops per strobe. Legal values are 2 to 4.
- `clk`  in  1  system clock. It is the only clock in the block.
- `reset_n`  in  1  asynchronous active-low reset.
- `sr`  in  38  JTAG shift-register contents. Stable from `vs_udr` rise until the next shift.
- `ir_in`  in  2  JTAG instruction: 00 ocimem, 01 trace readout, 10 break, 11 tracectrl.
- `vs_udr`  in  1  update-DR level, asynchronous to `clk`.
- `vs_uir`  in  1  update-IR level, asynchronous to `clk`.
- `jdo`  out  38  captured `sr`.
- `take_action_ocimem_a`, `take_action_ocimem_b`, `take_no_action_ocimem_a`  out  1 each  OCI memory command pulses.
- `take_action_break_a/b/c`, `take_no_action_break_a/b/c`  out  1 each  break command pulses.
- `take_action_tracectrl`  out  1  trace-control command pulse.
- `cmd_count`  out  16  present only with `DEBUG_CMD_COUNT_EN`.

## Operation
- **Synchronisers:** each strobe passes through a `SYNC_DEPTH`-flop synchroniser. `rise = s[last] & ~prev`, where `prev` is the registered copy of `s[last]`.
- **Arming after reset:** rise detection is disarmed at reset. It arms only after the synchronised strobe has been sampled low once. A strobe level already high at reset release never produces a pulse.
- **IR update:** `uir_rise` loads `ir_q <= ir_in`.
- **DR update:** `udr_rise` loads `jdo <= sr` and sets the `enable` register for exactly one cycle.
- **Decode:** outputs are combinational from the registered `enable`, `ir_q` and `jdo`. All are 0 when `enable` = 0.
  - `ir_q` = 00:
    - `ocimem_b` = `jdo[35]`.
    - `ocimem_a` = `~jdo[35] & jdo[34]`.
    - `no_ocimem_a` = `~jdo[35] & ~jdo[34]`.
  - `ir_q` = 10, with `a` = `~jdo[36]`, `b` = `jdo[36] & ~jdo[35]`, `c` = `jdo[36] & jdo[35]`:
    - `take_action_break_x` = x & `jdo[37]`.
    - `take_no_action_break_x` = x & `~jdo[37]`.
  - `ir_q` = 11: `tracectrl` = `jdo[15]`.
  - `ir_q` = 01: no pulse.
- **One-hot guarantee:** at most one `take_*` output is high in any cycle.
- **Simultaneous `uir_rise` and `udr_rise`:** both registers load on the same edge. The decode uses the new `ir_q`.
- **Back-to-back updates:** consecutive `udr_rise` events require the synchronised strobe to go low between them. Each rise yields exactly one pulse, and none are merged or dropped.

## Timing
- **Reset values:** `jdo` = 0, `ir_q` = 00, `enable` = 0, all `take_*` = 0, `cmd_count` = 0. Synchroniser and `prev` flops = 0, arm flags = 0.
- **Latency:** let E0 be the first `clk` edge sampling `vs_udr` = 1.
  - `jdo` updates at edge E(`SYNC_DEPTH`).
  - The `take_*` pulse is high for the single cycle following E(`SYNC_DEPTH`).
  - `jdo` holds that value until the next `udr_rise`.
- **`ir_q` latency:** same latency relative to `vs_uir`.
- **Minimum strobe widths:** `vs_udr`/`vs_uir` high ≥ 2 `clk` periods and low ≥ 2 `clk` periods, guaranteed by TCK ≤ clk/2.
- **Reset mid-operation:** asserting `reset_n` low clears all state immediately and asynchronously, including an in-flight pulse. Reset deassertion is synchronised externally.

## Configuration
- **`DEBUG_CMD_COUNT_EN` defined:** adds `cmd_count`, a 16-bit counter.
  - Increments at the edge where `jdo` loads.
  - Saturates at 0xFFFF.
  - Cleared by reset.
- **`DEBUG_CMD_COUNT_EN` undefined:** the port and logic are absent. Decode behaviour is identical in both builds.

## Test plan
- **OCI memory A:** `ir_in` = 00 with `vs_uir` pulse, then `sr` = 0x04_0000_1234 (bit34 = 1, bit35 = 0) with `vs_udr` pulse → `jdo` = 0x0400001234 at E2, and `take_action_ocimem_a` high for 1 cycle after E2. All other pulses stay 0.
- **Break sweep:** `ir_in` = 10, `sr[37:35]` = {1,0,0}, {0,1,0}, {1,1,1}, {0,1,1} → `take_action_break_a`, `take_no_action_break_b`, `take_action_break_c`, `take_no_action_break_c` respectively. Each is one pulse.
- **Trace readout and trace control:** `ir_in` = 01, `sr[15]` = 1 → no pulse. `ir_in` = 11, `sr[15]` = 1 → `take_action_tracectrl` pulse. `sr[15]` = 0 → no pulse.
- **Reset arming:** hold `vs_udr` high across reset release → no pulse and `jdo` stays 0. Drop low, then raise → one pulse.
- **Simultaneous strobes:** `vs_uir` and `vs_udr` rise on the same cycle with `ir_in` 00→10 → the decode uses 10.
- **Counter (`DEBUG_CMD_COUNT_EN`):** 3 updates → `cmd_count` = 3. Preload to 0xFFFE and apply 3 updates → 0xFFFF. Assert reset mid-pulse → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/sopc_cap_debug_slave_cmd_sync.sv
// System-clock side of the Nios II debug-slave JTAG path: synchronises update strobes, captures sr, decodes command pulses.
// Optional feature macro: DEBUG_CMD_COUNT_EN adds a saturating 16-bit cmd_count of captured DR updates.
module sopc_cap_debug_slave_cmd_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] sr,
  input  logic [1:0]  ir_in,
  input  logic        vs_udr,
  input  logic        vs_uir,
  output logic [37:0] jdo,
  output logic        take_action_ocimem_a,
  output logic        take_action_ocimem_b,
  output logic        take_no_action_ocimem_a,
  output logic        take_action_break_a,
  output logic        take_action_break_b,
  output logic        take_action_break_c,
  output logic        take_no_action_break_a,
  output logic        take_no_action_break_b,
  output logic        take_no_action_break_c,
`ifdef DEBUG_CMD_COUNT_EN
  output logic [15:0] cmd_count,
`endif
  output logic        take_action_tracectrl
);

  logic [1:0]            strobe_in;
  logic [1:0]            rise;
  logic [SYNC_DEPTH-1:0] fill_reg;
  logic                  udr_rise;
  logic                  uir_rise;
  logic [37:0]           jdo_reg;
  logic [1:0]            ir_q_reg;
  logic                  enable_reg;

  assign strobe_in = {vs_uir, vs_udr};

  // fill_reg[last] marks that the synchroniser outputs carry sampled data rather than reset zeros,
  // so a strobe held high through reset release is never mistaken for a low-to-high edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_reg <= '0;
    end else begin
      fill_reg <= {fill_reg[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_strobe
      logic [SYNC_DEPTH-1:0] sync_reg;
      logic                  prev_reg;
      logic                  armed_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg  <= '0;
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_DEPTH-2:0], strobe_in[gi]};
          prev_reg <= sync_reg[SYNC_DEPTH-1];
          if (fill_reg[SYNC_DEPTH-1] && !sync_reg[SYNC_DEPTH-1]) begin
            armed_reg <= 1'b1;
          end
        end
      end

      assign rise[gi] = sync_reg[SYNC_DEPTH-1] & ~prev_reg & armed_reg;
    end
  endgenerate

  assign udr_rise = rise[0];
  assign uir_rise = rise[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_reg    <= '0;
      ir_q_reg   <= 2'b00;
      enable_reg <= 1'b0;
    end else begin
      enable_reg <= udr_rise;
      if (uir_rise) begin
        ir_q_reg <= ir_in;
      end
      if (udr_rise) begin
        jdo_reg <= sr;
      end
    end
  end

  assign jdo = jdo_reg;

`ifdef DEBUG_CMD_COUNT_EN
  logic [15:0] cmd_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_count_reg <= '0;
    end else if (udr_rise && (cmd_count_reg != 16'hFFFF)) begin
      cmd_count_reg <= cmd_count_reg + 16'd1;
    end
  end

  assign cmd_count = cmd_count_reg;
`endif

  // Each instruction's terms are mutually exclusive, so at most one pulse is ever high.
  always_comb begin
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_break_a     = 1'b0;
    take_action_break_b     = 1'b0;
    take_action_break_c     = 1'b0;
    take_no_action_break_a  = 1'b0;
    take_no_action_break_b  = 1'b0;
    take_no_action_break_c  = 1'b0;
    take_action_tracectrl   = 1'b0;
    if (enable_reg) begin
      case (ir_q_reg)
        2'b00: begin
          take_action_ocimem_b    = jdo_reg[35];
          take_action_ocimem_a    = ~jdo_reg[35] & jdo_reg[34];
          take_no_action_ocimem_a = ~jdo_reg[35] & ~jdo_reg[34];
        end
        2'b10: begin
          take_action_break_a    = ~jdo_reg[36] & jdo_reg[37];
          take_action_break_b    = jdo_reg[36] & ~jdo_reg[35] & jdo_reg[37];
          take_action_break_c    = jdo_reg[36] & jdo_reg[35] & jdo_reg[37];
          take_no_action_break_a = ~jdo_reg[36] & ~jdo_reg[37];
          take_no_action_break_b = jdo_reg[36] & ~jdo_reg[35] & ~jdo_reg[37];
          take_no_action_break_c = jdo_reg[36] & jdo_reg[35] & ~jdo_reg[37];
        end
        2'b11: begin
          take_action_tracectrl = jdo_reg[15];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_cap_debug_slave_cmd_sync.sv
// Directed bench for sopc_cap_debug_slave_cmd_sync: strobe latency, decode table, reset arming and reset abort.
module tb_sopc_cap_debug_slave_cmd_sync;
  localparam int SD = 2;

  localparam logic [9:0] T_NONE   = 10'h000;
  localparam logic [9:0] T_OCI_A  = 10'h200;
  localparam logic [9:0] T_OCI_B  = 10'h100;
  localparam logic [9:0] T_NOCI_A = 10'h080;
  localparam logic [9:0] T_BRK_A  = 10'h040;
  localparam logic [9:0] T_BRK_B  = 10'h020;
  localparam logic [9:0] T_BRK_C  = 10'h010;
  localparam logic [9:0] T_NBRK_A = 10'h008;
  localparam logic [9:0] T_NBRK_B = 10'h004;
  localparam logic [9:0] T_NBRK_C = 10'h002;
  localparam logic [9:0] T_TRACE  = 10'h001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] sr = '0;
  logic [1:0]  ir_in = 2'b00;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic [37:0] jdo;
  logic        ta_oci_a, ta_oci_b, tna_oci_a;
  logic        ta_brk_a, ta_brk_b, ta_brk_c;
  logic        tna_brk_a, tna_brk_b, tna_brk_c;
  logic        ta_trace;
  logic [9:0]  take_vec;
`ifdef DEBUG_CMD_COUNT_EN
  logic [15:0] cmd_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [9:0]  obs_pre_take, obs_take;
  logic [37:0] obs_pre_jdo, obs_jdo;
  int          obs_pulses;

  always #5 clk = ~clk;

  assign take_vec = {ta_oci_a, ta_oci_b, tna_oci_a, ta_brk_a, ta_brk_b, ta_brk_c,
                     tna_brk_a, tna_brk_b, tna_brk_c, ta_trace};

  sopc_cap_debug_slave_cmd_sync #(.SYNC_DEPTH(SD)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .sr                      (sr),
    .ir_in                   (ir_in),
    .vs_udr                  (vs_udr),
    .vs_uir                  (vs_uir),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_oci_a),
    .take_action_ocimem_b    (ta_oci_b),
    .take_no_action_ocimem_a (tna_oci_a),
    .take_action_break_a     (ta_brk_a),
    .take_action_break_b     (ta_brk_b),
    .take_action_break_c     (ta_brk_c),
    .take_no_action_break_a  (tna_brk_a),
    .take_no_action_break_b  (tna_brk_b),
    .take_no_action_break_c  (tna_brk_c),
`ifdef DEBUG_CMD_COUNT_EN
    .cmd_count               (cmd_count),
`endif
    .take_action_tracectrl   (ta_trace)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic apply_uir(input logic [1:0] ir);
    @(negedge clk);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Raises vs_udr (and vs_uir too when with_uir) and records the window around edges E(SD-1)..E(SD+4).
  task automatic apply_cmd(input logic with_uir, input logic [1:0] ir, input logic [37:0] v);
    @(negedge clk);
    sr     = v;
    ir_in  = ir;
    vs_udr = 1'b1;
    if (with_uir) vs_uir = 1'b1;
    obs_pulses = 0;
    for (int i = 0; i <= SD + 4; i++) begin
      @(posedge clk);
      #1;
      if (take_vec != 10'h000) obs_pulses++;
      if (i == SD - 1) begin
        obs_pre_take = take_vec;
        obs_pre_jdo  = jdo;
      end
      if (i == SD) begin
        obs_take = take_vec;
        obs_jdo  = jdo;
        @(negedge clk);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
      end
    end
    $display("cmd uir=%0b ir=%b sr=%h -> jdo=%h take=%h pulses=%0d", with_uir, ir, v, obs_jdo, obs_take, obs_pulses);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (jdo !== 38'h0) begin miscompares++; $display("FAIL reset_jdo: got %h want %h", jdo, 38'h0); end
    vectors++;
    if (take_vec !== T_NONE) begin miscompares++; $display("FAIL reset_take: got %h want %h", take_vec, T_NONE); end
`ifdef DEBUG_CMD_COUNT_EN
    vectors++;
    if (cmd_count !== 16'h0) begin miscompares++; $display("FAIL reset_count: got %h want %h", cmd_count, 16'h0); end
`endif
    do_reset();
  endtask

  task automatic test_ocimem();
    logic [37:0] prev_jdo;
    prev_jdo = jdo;
    apply_uir(2'b00);
    apply_cmd(1'b0, 2'b00, 38'h04_0000_1234);
    vectors++;
    if (obs_pre_jdo !== prev_jdo) begin miscompares++; $display("FAIL oci_a_jdo_early: got %h want %h", obs_pre_jdo, prev_jdo); end
    vectors++;
    if (obs_pre_take !== T_NONE) begin miscompares++; $display("FAIL oci_a_take_early: got %h want %h", obs_pre_take, T_NONE); end
    vectors++;
    if (obs_jdo !== 38'h04_0000_1234) begin miscompares++; $display("FAIL oci_a_jdo: got %h want %h", obs_jdo, 38'h04_0000_1234); end
    vectors++;
    if (obs_take !== T_OCI_A) begin miscompares++; $display("FAIL oci_a_take: got %h want %h", obs_take, T_OCI_A); end
    vectors++;
    if (obs_pulses !== 1) begin miscompares++; $display("FAIL oci_a_pulses: got %0d want 1", obs_pulses); end
    vectors++;
    if (jdo !== 38'h04_0000_1234) begin miscompares++; $display("FAIL oci_a_jdo_hold: got %h want %h", jdo, 38'h04_0000_1234); end

    apply_cmd(1'b0, 2'b00, 38'h08_0000_0000);
    vectors++;
    if (obs_take !== T_OCI_B) begin miscompares++; $display("FAIL oci_b_take: got %h want %h", obs_take, T_OCI_B); end
    apply_cmd(1'b0, 2'b00, 38'h30_0000_0055);
    vectors++;
    if (obs_take !== T_NOCI_A) begin miscompares++; $display("FAIL no_oci_a_take: got %h want %h", obs_take, T_NOCI_A); end
  endtask

  task automatic test_break_sweep();
    logic [2:0] tops [6];
    logic [9:0] exps [6];
    logic [37:0] v;
    tops = '{3'b100, 3'b010, 3'b111, 3'b011, 3'b000, 3'b110};
    exps = '{T_BRK_A, T_NBRK_B, T_BRK_C, T_NBRK_C, T_NBRK_A, T_BRK_B};
    apply_uir(2'b10);
    for (int k = 0; k < 6; k++) begin
      v = {tops[k], 35'h0_1234_5678};
      apply_cmd(1'b0, 2'b10, v);
      vectors++;
      if (obs_take !== exps[k] || obs_pulses !== 1) begin
        miscompares++;
        $display("FAIL break_%b: got take %h pulses %0d want take %h pulses 1", tops[k], obs_take, obs_pulses, exps[k]);
      end
    end
  endtask

  task automatic test_trace();
    apply_uir(2'b01);
    apply_cmd(1'b0, 2'b01, 38'h00_0000_8000);
    vectors++;
    if (obs_pulses !== 0) begin miscompares++; $display("FAIL trace_readout: got %0d pulses want 0", obs_pulses); end
    vectors++;
    if (obs_jdo !== 38'h00_0000_8000) begin miscompares++; $display("FAIL trace_readout_jdo: got %h want %h", obs_jdo, 38'h00_0000_8000); end
    apply_uir(2'b11);
    apply_cmd(1'b0, 2'b11, 38'h3F_0000_8000);
    vectors++;
    if (obs_take !== T_TRACE || obs_pulses !== 1) begin
      miscompares++;
      $display("FAIL tracectrl_on: got take %h pulses %0d want take %h pulses 1", obs_take, obs_pulses, T_TRACE);
    end
    apply_cmd(1'b0, 2'b11, 38'h3F_FFFF_7FFF);
    vectors++;
    if (obs_pulses !== 0) begin miscompares++; $display("FAIL tracectrl_off: got %0d pulses want 0", obs_pulses); end
  endtask

  task automatic test_simultaneous();
    apply_uir(2'b00);
    apply_cmd(1'b1, 2'b10, {3'b100, 35'h0});
    vectors++;
    if (obs_take !== T_BRK_A) begin miscompares++; $display("FAIL simultaneous: got %h want %h", obs_take, T_BRK_A); end
  endtask

  task automatic test_back_to_back();
    logic [37:0] vals [3];
    logic [9:0]  exps [3];
    vals = '{{3'b100, 35'h1}, {3'b110, 35'h2}, {3'b011, 35'h3}};
    exps = '{T_BRK_A, T_BRK_B, T_NBRK_C};
    apply_uir(2'b10);
    for (int k = 0; k < 3; k++) begin
      apply_cmd(1'b0, 2'b10, vals[k]);
      vectors++;
      if (obs_take !== exps[k] || obs_pulses !== 1 || obs_jdo !== vals[k]) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got take %h pulses %0d jdo %h want take %h pulses 1 jdo %h",
                 k, obs_take, obs_pulses, obs_jdo, exps[k], vals[k]);
      end
    end
  endtask

  task automatic test_reset_arming();
    logic [9:0] seen;
    @(negedge clk);
    reset_n = 1'b0;
    sr      = 38'h04_0000_0001;
    vs_udr  = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen = seen | take_vec;
    end
    vectors++;
    if (seen !== T_NONE) begin miscompares++; $display("FAIL arm_held_high_take: got %h want %h", seen, T_NONE); end
    vectors++;
    if (jdo !== 38'h0) begin miscompares++; $display("FAIL arm_held_high_jdo: got %h want %h", jdo, 38'h0); end
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(posedge clk);
    apply_cmd(1'b0, 2'b00, 38'h04_0000_0001);
    vectors++;
    if (obs_take !== T_OCI_A || obs_pulses !== 1) begin
      miscompares++;
      $display("FAIL arm_after_low: got take %h pulses %0d want take %h pulses 1", obs_take, obs_pulses, T_OCI_A);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [9:0] inflight;
    apply_uir(2'b00);
    @(negedge clk);
    sr     = 38'h04_0000_00AA;
    vs_udr = 1'b1;
    repeat (SD + 1) @(posedge clk);
    #1;
    inflight = take_vec;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (inflight !== T_OCI_A) begin miscompares++; $display("FAIL mid_pulse_inflight: got %h want %h", inflight, T_OCI_A); end
    vectors++;
    if (take_vec !== T_NONE) begin miscompares++; $display("FAIL mid_pulse_take: got %h want %h", take_vec, T_NONE); end
    vectors++;
    if (jdo !== 38'h0) begin miscompares++; $display("FAIL mid_pulse_jdo: got %h want %h", jdo, 38'h0); end
`ifdef DEBUG_CMD_COUNT_EN
    vectors++;
    if (cmd_count !== 16'h0) begin miscompares++; $display("FAIL mid_pulse_count: got %h want %h", cmd_count, 16'h0); end
`endif
    @(negedge clk);
    vs_udr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

`ifdef DEBUG_CMD_COUNT_EN
  task automatic test_counter();
    do_reset();
    for (int k = 0; k < 3; k++) apply_cmd(1'b0, 2'b00, 38'(k));
    vectors++;
    if (cmd_count !== 16'd3) begin miscompares++; $display("FAIL count_three: got %h want %h", cmd_count, 16'd3); end
    @(negedge clk);
    force dut.cmd_count_reg = 16'hFFFE;
    @(negedge clk);
    release dut.cmd_count_reg;
    for (int k = 0; k < 3; k++) apply_cmd(1'b0, 2'b00, 38'(k));
    vectors++;
    if (cmd_count !== 16'hFFFF) begin miscompares++; $display("FAIL count_saturate: got %h want %h", cmd_count, 16'hFFFF); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_ocimem();
    test_break_sweep();
    test_trace();
    test_simultaneous();
    test_back_to_back();
    test_reset_arming();
    test_reset_mid_pulse();
`ifdef DEBUG_CMD_COUNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
